// File: rtl/shared_buffer_mq_pkg.sv
// Shared constants and index-width helper for the multi-queue shared cell buffer.
package shared_buffer_mq_pkg;

    localparam int DEF_DATA_W = 72;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NPORT  = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_buffer_mq_if.sv
// Ingress-write / egress-read bus of the shared cell buffer, plus status outputs.
interface shared_buffer_mq_if
    import shared_buffer_mq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NPORT  = DEF_NPORT
);
    localparam int ADDR_W = idx_w(DEPTH);
    localparam int PORT_W = idx_w(NPORT);

    logic              wr_req;
    logic [PORT_W-1:0] ip;
    logic [DATA_W-1:0] idata;
    logic              rd_req;
    logic [PORT_W-1:0] rd_port;
    logic [PORT_W-1:0] op;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic              wr_drop;
    logic              rd_err;
    logic [NPORT-1:0]  q_empty;
    logic [ADDR_W:0]   free_cnt;

    modport slave (
        input  wr_req, ip, idata, rd_req, rd_port,
        output op, odata, ovalid, wr_drop, rd_err, q_empty, free_cnt
    );

    modport master (
        output wr_req, ip, idata, rd_req, rd_port,
        input  op, odata, ovalid, wr_drop, rd_err, q_empty, free_cnt
    );

endinterface

// File: rtl/shared_buffer_mq_free_list.sv
// Ring FIFO of free cell addresses; starts full with 0..DEPTH-1, one pop and one push per clk.
module shared_buffer_mq_free_list
    import shared_buffer_mq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int ADDR_W = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    output logic [ADDR_W-1:0] pop_addr_o,
    output logic [ADDR_W:0]   cnt_o
);

    logic [ADDR_W-1:0] ring_q [DEPTH];
    logic [ADDR_W-1:0] head_q, tail_q;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // Cells are conserved, so a push never lands on a full ring and pop never hits an empty one.
    assign cnt_d      = cnt_q + (ADDR_W+1)'(push_i) - (ADDR_W+1)'(pop_i);
    assign pop_addr_o = ring_q[head_q];
    assign cnt_o      = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= ADDR_W'(i);
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= (ADDR_W+1)'(DEPTH);
        end else begin
            if (push_i) begin
                ring_q[tail_q] <= push_addr_i;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop_i) head_q <= head_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shared_buffer_mq.sv
// Shared-memory cell buffer: one data RAM pooled by NPORT linked-list queues and a free list.
module shared_buffer_mq
    import shared_buffer_mq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NPORT  = DEF_NPORT
) (
    input  logic               clk,
    input  logic               rst,
    shared_buffer_mq_if.slave  bus
);

    localparam int ADDR_W = idx_w(DEPTH);
    localparam int PORT_W = idx_w(NPORT);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] data_ram [DEPTH];
    logic [ADDR_W-1:0] next_ram [DEPTH];

    logic [ADDR_W-1:0] head_q [NPORT], head_d [NPORT];
    logic [ADDR_W-1:0] tail_q [NPORT], tail_d [NPORT];
    logic [CNT_W-1:0]  cnt_q  [NPORT], cnt_d  [NPORT];

    logic [PORT_W-1:0] op_q;
    logic [DATA_W-1:0] odata_q;
    logic              ovalid_q, wr_drop_q, rd_err_q;

    logic [ADDR_W-1:0] alloc_addr, rd_head, wr_tail;
    logic [CNT_W-1:0]  free_cnt;
    logic              wr_port_ok, rd_port_ok, wr_ok, rd_ok, wr_was_empty;
    logic [NPORT-1:0]  wr_sel, rd_sel, q_empty;

    assign wr_port_ok   = {1'b0, bus.ip} < (PORT_W+1)'(NPORT);
    assign rd_port_ok   = {1'b0, bus.rd_port} < (PORT_W+1)'(NPORT);
    assign wr_ok        = bus.wr_req && wr_port_ok && (free_cnt != '0);
    assign rd_ok        = bus.rd_req && rd_port_ok && (cnt_q[bus.rd_port] != '0);
    assign rd_head      = head_q[bus.rd_port];
    assign wr_tail      = tail_q[bus.ip];
    assign wr_was_empty = (cnt_q[bus.ip] == '0);

    shared_buffer_mq_free_list #(.DEPTH(DEPTH)) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .pop_i       (wr_ok),
        .push_i      (rd_ok),
        .push_addr_i (rd_head),
        .pop_addr_o  (alloc_addr),
        .cnt_o       (free_cnt)
    );

    always_comb begin
        wr_sel  = '0;
        rd_sel  = '0;
        q_empty = '0;
        for (int p = 0; p < NPORT; p++) begin
            wr_sel[p]  = wr_ok && (bus.ip == PORT_W'(p));
            rd_sel[p]  = rd_ok && (bus.rd_port == PORT_W'(p));
            q_empty[p] = (cnt_q[p] == '0);
            head_d[p]  = head_q[p];
            tail_d[p]  = tail_q[p];
            if (wr_sel[p]) begin
                tail_d[p] = alloc_addr;
                if (cnt_q[p] == '0) head_d[p] = alloc_addr;
            end
            // A single-cell queue popped while appended: next[H] is being written this clk.
            if (rd_sel[p])
                head_d[p] = (wr_sel[p] && cnt_q[p] == CNT_W'(1)) ? alloc_addr : next_ram[head_q[p]];
            cnt_d[p] = cnt_q[p] + CNT_W'(wr_sel[p]) - CNT_W'(rd_sel[p]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                head_q[p] <= '0;
                tail_q[p] <= '0;
                cnt_q[p]  <= '0;
            end
            op_q      <= '0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            wr_drop_q <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                head_q[p] <= head_d[p];
                tail_q[p] <= tail_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
            if (rd_ok) begin
                op_q    <= bus.rd_port;
                odata_q <= data_ram[rd_head];
            end
            ovalid_q  <= rd_ok;
            wr_drop_q <= bus.wr_req && !wr_ok;
            rd_err_q  <= bus.rd_req && !rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data_ram[alloc_addr] <= bus.idata;
            if (!wr_was_empty) next_ram[wr_tail] <= alloc_addr;
        end
    end

    assign bus.op       = op_q;
    assign bus.odata    = odata_q;
    assign bus.ovalid   = ovalid_q;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.q_empty  = q_empty;
    assign bus.free_cnt = free_cnt;

endmodule

// File: tb/tb_shared_buffer_mq.sv
// Scoreboard bench for shared_buffer_mq with DEPTH=8, NPORT=4, DATA_W=8.
module tb_shared_buffer_mq;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int NPORT  = 4;

    typedef struct packed {
        logic [1:0] p;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        logic       wr;
        logic [1:0] wp;
        logic [7:0] wd;
        logic       rd;
        logic [1:0] rp;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_buffer_mq_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NPORT(NPORT)) bus ();

    shared_buffer_mq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NPORT(NPORT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sbq [$];
    logic [7:0] mq [4][$];
    int   mfree;
    logic exp_vld, exp_drop, exp_err;

    function automatic logic [3:0] m_empty();
        logic [3:0] e;
        for (int p = 0; p < NPORT; p++) e[p] = (mq[p].size() == 0);
        return e;
    endfunction

    function automatic int m_used();
        int s = 0;
        for (int p = 0; p < NPORT; p++) s += mq[p].size();
        return s;
    endfunction

    function automatic op_t mk(input logic wr, input logic [1:0] wp, input logic [7:0] wd,
                               input logic rd, input logic [1:0] rp);
        op_t o;
        o.wr = wr; o.wp = wp; o.wd = wd; o.rd = rd; o.rp = rp;
        return o;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPORT; p++) mq[p].delete();
        sbq.delete();
        mfree    = DEPTH;
        exp_vld  = 1'b0;
        exp_drop = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Drive one clk of stimulus, advance the model, and leave the bench just after the edge.
    task automatic step(input op_t o);
        logic wok, rok;
        exp_t e;
        @(negedge clk);
        bus.wr_req  = o.wr;
        bus.ip      = o.wp;
        bus.idata   = o.wd;
        bus.rd_req  = o.rd;
        bus.rd_port = o.rp;
        wok = o.wr && (mfree != 0);
        rok = o.rd && (mq[o.rp].size() != 0);
        if (rok) begin
            e.p = o.rp;
            e.d = mq[o.rp].pop_front();
            sbq.push_back(e);
        end
        if (wok) mq[o.wp].push_back(o.wd);
        mfree    = mfree + int'(rok) - int'(wok);
        exp_vld  = rok;
        exp_drop = o.wr && !wok;
        exp_err  = o.rd && !rok;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op_t o;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.free_cnt !== 4'd8) begin errors++; $display("FAIL reset_free_cnt: got %0d expected 8", bus.free_cnt); end
        checks++; if (bus.q_empty !== 4'hf) begin errors++; $display("FAIL reset_q_empty: got %b expected 1111", bus.q_empty); end
        checks++; if ({bus.ovalid, bus.wr_drop, bus.rd_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {bus.ovalid, bus.wr_drop, bus.rd_err}); end
        checks++; if ({bus.op, bus.odata} !== 10'd0) begin errors++; $display("FAIL reset_out: got %0h expected 0", {bus.op, bus.odata}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        o = mk(1'b0, 2'd0, 8'd0, 1'b1, 2'd0);
        step(o);
        checks++; if (bus.rd_err !== 1'b1) begin errors++; $display("FAIL reset_rd_err: got %b expected 1", bus.rd_err); end
        checks++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL reset_rd_ovalid: got %b expected 0", bus.ovalid); end
        o = mk(1'b0, 2'd0, 8'd0, 1'b0, 2'd0);
        step(o);
    endtask

    task automatic test_basic();
        op_t  ops [$];
        exp_t e;
        ops.push_back(mk(1'b1, 2'd1, 8'd13, 1'b0, 2'd0));
        ops.push_back(mk(1'b1, 2'd1, 8'd2,  1'b0, 2'd0));
        ops.push_back(mk(1'b1, 2'd3, 8'd7,  1'b0, 2'd0));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b1, 2'd1));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b1, 2'd1));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b1, 2'd3));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b0, 2'd0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++; if (bus.ovalid !== exp_vld) begin errors++; $display("FAIL basic_ovalid[%0d]: got %b expected %b", i, bus.ovalid, exp_vld); end
            if (bus.ovalid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++; if ({bus.op, bus.odata} !== {e.p, e.d}) begin errors++; $display("FAIL basic_data[%0d]: got p%0d %0d expected p%0d %0d", i, bus.op, bus.odata, e.p, e.d); end
            end
            checks++; if ({bus.wr_drop, bus.rd_err} !== {exp_drop, exp_err}) begin errors++; $display("FAIL basic_flags[%0d]: got %b expected %b", i, {bus.wr_drop, bus.rd_err}, {exp_drop, exp_err}); end
            checks++; if (bus.free_cnt !== 4'(mfree)) begin errors++; $display("FAIL basic_free_cnt[%0d]: got %0d expected %0d", i, bus.free_cnt, mfree); end
            checks++; if (bus.q_empty !== m_empty()) begin errors++; $display("FAIL basic_q_empty[%0d]: got %b expected %b", i, bus.q_empty, m_empty()); end
        end
    endtask

    task automatic test_full();
        op_t  ops [$];
        exp_t e;
        for (int i = 0; i < 9; i++) ops.push_back(mk(1'b1, 2'd0, 8'(i), 1'b0, 2'd0));
        for (int i = 0; i < 9; i++) ops.push_back(mk(1'b0, 2'd0, 8'd0, 1'b1, 2'd0));
        ops.push_back(mk(1'b0, 2'd0, 8'd0, 1'b0, 2'd0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++; if (bus.ovalid !== exp_vld) begin errors++; $display("FAIL full_ovalid[%0d]: got %b expected %b", i, bus.ovalid, exp_vld); end
            if (bus.ovalid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++; if ({bus.op, bus.odata} !== {e.p, e.d}) begin errors++; $display("FAIL full_data[%0d]: got p%0d %0d expected p%0d %0d", i, bus.op, bus.odata, e.p, e.d); end
            end
            checks++; if ({bus.wr_drop, bus.rd_err} !== {exp_drop, exp_err}) begin errors++; $display("FAIL full_flags[%0d]: got %b expected %b", i, {bus.wr_drop, bus.rd_err}, {exp_drop, exp_err}); end
            checks++; if (bus.free_cnt !== 4'(mfree)) begin errors++; $display("FAIL full_free_cnt[%0d]: got %0d expected %0d", i, bus.free_cnt, mfree); end
            checks++; if (bus.q_empty !== m_empty()) begin errors++; $display("FAIL full_q_empty[%0d]: got %b expected %b", i, bus.q_empty, m_empty()); end
        end
    endtask

    task automatic test_full_simul();
        op_t  ops [$];
        exp_t e;
        for (int i = 0; i < 8; i++) ops.push_back(mk(1'b1, 2'd0, 8'h40 + 8'(i), 1'b0, 2'd0));
        ops.push_back(mk(1'b1, 2'd2, 8'hAA, 1'b1, 2'd0));
        ops.push_back(mk(1'b1, 2'd2, 8'hAA, 1'b0, 2'd0));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b1, 2'd2));
        for (int i = 0; i < 7; i++) ops.push_back(mk(1'b0, 2'd0, 8'd0, 1'b1, 2'd0));
        ops.push_back(mk(1'b0, 2'd0, 8'd0, 1'b0, 2'd0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++; if (bus.ovalid !== exp_vld) begin errors++; $display("FAIL simul_ovalid[%0d]: got %b expected %b", i, bus.ovalid, exp_vld); end
            if (bus.ovalid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++; if ({bus.op, bus.odata} !== {e.p, e.d}) begin errors++; $display("FAIL simul_data[%0d]: got p%0d %0h expected p%0d %0h", i, bus.op, bus.odata, e.p, e.d); end
            end
            checks++; if ({bus.wr_drop, bus.rd_err} !== {exp_drop, exp_err}) begin errors++; $display("FAIL simul_flags[%0d]: got %b expected %b", i, {bus.wr_drop, bus.rd_err}, {exp_drop, exp_err}); end
            checks++; if (bus.free_cnt !== 4'(mfree)) begin errors++; $display("FAIL simul_free_cnt[%0d]: got %0d expected %0d", i, bus.free_cnt, mfree); end
            checks++; if (bus.q_empty !== m_empty()) begin errors++; $display("FAIL simul_q_empty[%0d]: got %b expected %b", i, bus.q_empty, m_empty()); end
        end
    endtask

    task automatic test_same_queue();
        op_t  ops [$];
        exp_t e;
        ops.push_back(mk(1'b1, 2'd1, 8'h11, 1'b0, 2'd0));
        ops.push_back(mk(1'b1, 2'd1, 8'h22, 1'b1, 2'd1));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b1, 2'd1));
        ops.push_back(mk(1'b1, 2'd2, 8'h33, 1'b1, 2'd2));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b1, 2'd2));
        ops.push_back(mk(1'b0, 2'd0, 8'd0,  1'b0, 2'd0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++; if (bus.ovalid !== exp_vld) begin errors++; $display("FAIL sameq_ovalid[%0d]: got %b expected %b", i, bus.ovalid, exp_vld); end
            if (bus.ovalid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++; if ({bus.op, bus.odata} !== {e.p, e.d}) begin errors++; $display("FAIL sameq_data[%0d]: got p%0d %0h expected p%0d %0h", i, bus.op, bus.odata, e.p, e.d); end
            end
            checks++; if ({bus.wr_drop, bus.rd_err} !== {exp_drop, exp_err}) begin errors++; $display("FAIL sameq_flags[%0d]: got %b expected %b", i, {bus.wr_drop, bus.rd_err}, {exp_drop, exp_err}); end
            checks++; if (bus.free_cnt !== 4'(mfree)) begin errors++; $display("FAIL sameq_free_cnt[%0d]: got %0d expected %0d", i, bus.free_cnt, mfree); end
            checks++; if (bus.q_empty !== m_empty()) begin errors++; $display("FAIL sameq_q_empty[%0d]: got %b expected %b", i, bus.q_empty, m_empty()); end
        end
    endtask

    task automatic test_random();
        op_t  o;
        exp_t e;
        int   wprob;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                checks++; if (bus.free_cnt !== 4'd8) begin errors++; $display("FAIL rand_rst_free_cnt: got %0d expected 8", bus.free_cnt); end
                checks++; if (bus.q_empty !== 4'hf) begin errors++; $display("FAIL rand_rst_q_empty: got %b expected 1111", bus.q_empty); end
                checks++; if ({bus.ovalid, bus.wr_drop, bus.rd_err} !== 3'b000) begin errors++; $display("FAIL rand_rst_pulses: got %b expected 000", {bus.ovalid, bus.wr_drop, bus.rd_err}); end
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            wprob = ((i / 400) % 2 == 1) ? 75 : 35;
            o = mk($urandom_range(0, 99) < wprob, 2'($urandom_range(0, 3)), 8'($urandom),
                   $urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)));
            step(o);
            checks++; if (bus.ovalid !== exp_vld) begin errors++; $display("FAIL rand_ovalid[%0d]: got %b expected %b", i, bus.ovalid, exp_vld); end
            if (bus.ovalid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++; if ({bus.op, bus.odata} !== {e.p, e.d}) begin errors++; $display("FAIL rand_data[%0d]: got p%0d %0h expected p%0d %0h", i, bus.op, bus.odata, e.p, e.d); end
            end
            checks++; if ({bus.wr_drop, bus.rd_err} !== {exp_drop, exp_err}) begin errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", i, {bus.wr_drop, bus.rd_err}, {exp_drop, exp_err}); end
            checks++; if (int'(bus.free_cnt) + m_used() != DEPTH) begin errors++; $display("FAIL rand_invariant[%0d]: got free %0d + used %0d expected sum 8", i, bus.free_cnt, m_used()); end
            checks++; if (bus.q_empty !== m_empty()) begin errors++; $display("FAIL rand_q_empty[%0d]: got %b expected %b", i, bus.q_empty, m_empty()); end
        end
        o = mk(1'b0, 2'd0, 8'd0, 1'b0, 2'd0);
        step(o);
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.ip      = '0;
        bus.idata   = '0;
        bus.rd_req  = 1'b0;
        bus.rd_port = '0;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_full_simul();
        test_same_queue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within 2000000 time units");
        $fatal(1, "timeout");
    end

endmodule
